// File: rtl/harvard_data_ram.sv
// Data-side RAM for the Harvard MIPS benches: byte-lane writes, pipelined reads
// with a valid strobe, fault pulse on bad accesses and saturating access counters.
module harvard_data_ram #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_readvalid,
    output logic        access_fault,
    output logic [15:0] read_count,
    output logic [15:0] write_count
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    logic [31:0] offset;
    logic [AW-1:0] index;
    logic        in_range, aligned, req, accept, fault;

    always_comb begin
        offset   = data_address - BASE_ADDR;
        in_range = offset < SPAN;
        aligned  = data_address[1:0] == 2'b00;
        index    = offset[AW+1:2];
        req      = clk_enable & (data_read | data_write);
        accept   = req & in_range & aligned;
        fault    = req & ~(in_range & aligned);
    end

    // Zero at time 0 only; reset deliberately leaves the contents alone.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (accept && data_write) begin
            for (int b = 0; b < 4; b++) begin
                if (data_byteenable[b]) mem[index][8*b +: 8] <= data_writedata[8*b +: 8];
            end
        end
    end

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             pdata_q [READ_LATENCY];
    logic [31:0]             pdata_d [READ_LATENCY];
    logic [31:0]             readdata_q, readdata_d;
    logic                    readvalid_q, readvalid_d;
    logic                    fault_q, fault_d;
    logic [15:0]             read_count_q, read_count_d;
    logic [15:0]             write_count_q, write_count_d;

    always_comb begin
        vld_d         = vld_q;
        pdata_d       = pdata_q;
        readdata_d    = readdata_q;
        readvalid_d   = readvalid_q;
        fault_d       = fault_q;
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (clk_enable) begin
            // Stage 0 samples the array before this edge's write lands,
            // giving read-before-write on a same-word collision.
            vld_d[0] = req & data_read;
            if (req && data_read) pdata_d[0] = accept ? mem[index] : 32'h0000_0000;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_d[i]   = vld_q[i-1];
                pdata_d[i] = pdata_q[i-1];
            end
            readvalid_d = vld_q[READ_LATENCY-1];
            if (vld_q[READ_LATENCY-1]) readdata_d = pdata_q[READ_LATENCY-1];
            fault_d = fault;
            if (accept && data_read && read_count_q != 16'hFFFF)
                read_count_d = read_count_q + 16'd1;
            if (accept && data_write && write_count_q != 16'hFFFF)
                write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q         <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pdata_q[i] <= '0;
            readdata_q    <= '0;
            readvalid_q   <= 1'b0;
            fault_q       <= 1'b0;
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            vld_q         <= vld_d;
            pdata_q       <= pdata_d;
            readdata_q    <= readdata_d;
            readvalid_q   <= readvalid_d;
            fault_q       <= fault_d;
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign data_readdata  = readdata_q;
    assign data_readvalid = readvalid_q;
    assign access_fault   = fault_q;
    assign read_count     = read_count_q;
    assign write_count    = write_count_q;

    addr_known_a: assert property (@(posedge clk) disable iff (reset)
        (clk_enable && (data_read || data_write)) |-> !$isunknown(data_address))
        else $error("harvard_data_ram: X on data_address during request");

endmodule
